// File: rtl/otsu_threshold_sequencer.sv
// Otsu threshold search over a 256-bin histogram with a serial restoring divider.
// Optional build macro OTSU_SKIP_EMPTY_BIN_EN: candidate bins with a zero count skip the divide.
module otsu_threshold_sequencer #(
   parameter  int CNT_W = 20,
   localparam int Q_W   = 2*(2*CNT_W+8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] total_count,
   input  logic [CNT_W+7:0] total_sum,
   output logic             hist_rd,
   output logic [7:0]       hist_addr,
   input  logic [CNT_W-1:0] hist_data,
   output logic             busy,
   output logic             done,
   output logic [7:0]       threshold,
   output logic [Q_W-1:0]   best_metric
);

   localparam int P_W  = 2*CNT_W+8;
   localparam int D_W  = 2*CNT_W;
   localparam int DC_W = $clog2(Q_W);

   typedef enum logic [2:0] {IDLE, READ, WAIT, ACC, DIV, CMP, DONE} state_e;

   state_e           state, state_n;
   logic [7:0]       t, best_t;
   logic [CNT_W-1:0] n_q, w_b, bin_q;
   logic [CNT_W+7:0] s_q, sum_b;
   logic [Q_W-1:0]   quo;
   logic [D_W-1:0]   rem, den;
   logic [DC_W-1:0]  div_cnt;

   logic [CNT_W-1:0] w_b_n, w_f_n;
   logic [CNT_W+7:0] sum_b_n, t_x_bin;
   logic [P_W-1:0]   prod_s, prod_n, diff;
   logic [Q_W-1:0]   numer;
   logic [D_W-1:0]   denom, rem_next;
   logic [D_W:0]     trial;
   logic             trial_ge, candidate, div_needed, better, last_bin, div_last;

   // Bin statistics including the current bin, used both for the candidate test and the divider load.
   always_comb begin
      t_x_bin  = (CNT_W+8)'(t) * (CNT_W+8)'(bin_q);
      w_b_n    = w_b + bin_q;
      sum_b_n  = sum_b + t_x_bin;
      w_f_n    = (w_b_n > n_q) ? '0 : n_q - w_b_n;
      candidate = (w_b_n != '0) && (w_f_n != '0);
`ifdef OTSU_SKIP_EMPTY_BIN_EN
      div_needed = candidate && (bin_q != '0);
`else
      div_needed = candidate;
`endif
      prod_s   = P_W'(s_q) * P_W'(w_b_n);
      prod_n   = P_W'(n_q) * P_W'(sum_b_n);
      diff     = (prod_s >= prod_n) ? prod_s - prod_n : prod_n - prod_s;
      numer    = Q_W'(diff) * Q_W'(diff);
      denom    = D_W'(w_b_n) * D_W'(w_f_n);
      trial    = {rem, quo[Q_W-1]};
      trial_ge = trial >= {1'b0, den};
      rem_next = trial_ge ? D_W'(trial - {1'b0, den}) : trial[D_W-1:0];
      div_last = div_cnt == DC_W'(Q_W-1);
      better   = quo > best_metric;
      last_bin = t == 8'hFF;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      hist_rd   = 1'b0;
      hist_addr = t;
      busy      = (state != IDLE) && (state != DONE);
      done      = state == DONE;
      case (state)
         IDLE: if (start) state_n = (total_count == '0) ? DONE : READ;
         READ: begin
            hist_rd = 1'b1;
            state_n = WAIT;
         end
         WAIT: state_n = ACC;
         ACC:  begin
            if (div_needed)    state_n = DIV;
            else if (last_bin) state_n = DONE;
            else               state_n = READ;
         end
         DIV:  if (div_last) state_n = CMP;
         CMP:  state_n = last_bin ? DONE : READ;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_q         <= '0;
         s_q         <= '0;
         t           <= '0;
         w_b         <= '0;
         sum_b       <= '0;
         bin_q       <= '0;
         quo         <= '0;
         rem         <= '0;
         den         <= '0;
         div_cnt     <= '0;
         best_t      <= '0;
         best_metric <= '0;
         threshold   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               n_q         <= total_count;
               s_q         <= total_sum;
               t           <= '0;
               w_b         <= '0;
               sum_b       <= '0;
               best_metric <= '0;
               best_t      <= '0;
            end
            WAIT: bin_q <= hist_data;
            ACC: begin
               w_b   <= w_b_n;
               sum_b <= sum_b_n;
               if (div_needed) begin
                  quo     <= numer;
                  den     <= denom;
                  rem     <= '0;
                  div_cnt <= '0;
               end else if (!last_bin) begin
                  t <= t + 8'd1;
               end
            end
            DIV: begin
               quo     <= {quo[Q_W-2:0], trial_ge};
               rem     <= rem_next;
               div_cnt <= div_cnt + DC_W'(1);
            end
            CMP: begin
               if (better) begin
                  best_metric <= quo;
                  best_t      <= t;
               end
               if (!last_bin) t <= t + 8'd1;
            end
            default: ;
         endcase
         // The winner may be decided on the same edge that enters DONE, so forward it.
         if (state_n == DONE) begin
            if (state == IDLE)             threshold <= '0;
            else if (state == CMP && better) threshold <= t;
            else                           threshold <= best_t;
         end
      end
   end

endmodule

// File: tb/tb_otsu_threshold_sequencer.sv
// Directed bench for otsu_threshold_sequencer with a one-cycle-latency histogram RAM model.
module tb_otsu_threshold_sequencer;

   localparam int CNT_W = 20;
   localparam int Q_W   = 2*(2*CNT_W+8);
`ifdef OTSU_SKIP_EMPTY_BIN_EN
   localparam int N_DIV = 1;
`else
   localparam int N_DIV = 190;
`endif
   localparam int CYC_SWEEP = 768;
   localparam int CYC_BIMODAL = CYC_SWEEP + N_DIV*(Q_W+1);
   localparam logic [Q_W-1:0] METRIC_BIMODAL = Q_W'(361000000);

   logic             clk, reset, start;
   logic [CNT_W-1:0] total_count, hist_data;
   logic [CNT_W+7:0] total_sum;
   logic             hist_rd, busy, done;
   logic [7:0]       hist_addr, threshold;
   logic [Q_W-1:0]   best_metric;

   logic [CNT_W-1:0] mem [256];
   int n_assert, n_fail;
   int rd_cnt, done_cnt, addr_bad, cyc;

   otsu_threshold_sequencer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .total_count(total_count), .total_sum(total_sum),
      .hist_rd(hist_rd), .hist_addr(hist_addr), .hist_data(hist_data),
      .busy(busy), .done(done), .threshold(threshold), .best_metric(best_metric)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (hist_rd) hist_data <= mem[hist_addr];

   always @(negedge clk) begin
      if (hist_rd) begin
         if (hist_addr != 8'(rd_cnt)) addr_bad++;
         rd_cnt++;
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic kick(input logic [CNT_W-1:0] n, input logic [CNT_W+7:0] s);
      rd_cnt = 0; done_cnt = 0; addr_bad = 0;
      total_count = n; total_sum = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      check("busy_after_start", busy, (n != '0));
      check("metric_cleared", best_metric, '0);
   endtask

   task automatic wait_done();
      while (done !== 1'b1 && cyc < 40000) begin
         @(posedge clk); #1; cyc++;
      end
      check("done_seen", done, 1'b1);
   endtask

   task automatic after_done(input string tag);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, done, 1'b0);
      check({tag, "_busy_low"}, busy, 1'b0);
      check({tag, "_done_count"}, done_cnt, 1);
   endtask

   task automatic wait_addr(input logic [7:0] a);
      while (!(hist_rd === 1'b1 && hist_addr == a) && cyc < 40000) begin
         @(posedge clk); #1; cyc++;
      end
      check("addr_reached", hist_addr, a);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      rd_cnt = 0; done_cnt = 0; addr_bad = 0; cyc = 0;
      reset = 1'b1; start = 1'b0; total_count = '0; total_sum = '0; hist_data = '0;
      clear_mem();
      repeat (2) @(posedge clk);
      #1;
      check("rst_hist_rd", hist_rd, 1'b0);
      check("rst_hist_addr", hist_addr, 8'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_threshold", threshold, 8'd0);
      check("rst_metric", best_metric, '0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single populated bin: no candidate anywhere
      clear_mem();
      mem[128] = 20'd50;
      kick(20'd50, 28'd6400);
      wait_done();
      check("single_threshold", threshold, 8'd0);
      check("single_metric", best_metric, '0);
      check("single_cycles", cyc, CYC_SWEEP);
      check("single_reads", rd_cnt, 256);
      check("single_addr_order", addr_bad, 0);
      after_done("single");

      // Empty image
      kick(20'd0, 28'd0);
      wait_done();
      check("empty_cycles", cyc, 0);
      check("empty_threshold", threshold, 8'd0);
      check("empty_metric", best_metric, '0);
      after_done("empty");
      check("empty_no_reads", rd_cnt, 0);

      // Bimodal histogram
      clear_mem();
      mem[10] = 20'd100;
      mem[200] = 20'd100;
      kick(20'd200, 28'd21000);
      wait_done();
      check("bimodal_threshold", threshold, 8'd10);
      check("bimodal_metric", best_metric, METRIC_BIMODAL);
      check("bimodal_cycles", cyc, CYC_BIMODAL);
      check("bimodal_reads", rd_cnt, 256);
      check("bimodal_addr_order", addr_bad, 0);
      after_done("bimodal");
      check("bimodal_threshold_held", threshold, 8'd10);

      // start re-asserted mid-sweep with different N/S is ignored
      kick(20'd200, 28'd21000);
      wait_addr(8'd50);
      start = 1'b1; total_count = 20'd7; total_sum = 28'd9;
      @(posedge clk); #1; cyc++;
      start = 1'b0;
      wait_done();
      check("midstart_threshold", threshold, 8'd10);
      check("midstart_metric", best_metric, METRIC_BIMODAL);
      check("midstart_cycles", cyc, CYC_BIMODAL);
      check("midstart_reads", rd_cnt, 256);
      check("midstart_addr_order", addr_bad, 0);
      after_done("midstart");

      // Reset during the divide at t=20 aborts the sweep
      kick(20'd200, 28'd21000);
      wait_addr(8'd20);
      repeat (10) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("abort_hist_rd", hist_rd, 1'b0);
      check("abort_hist_addr", hist_addr, 8'd0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_threshold", threshold, 8'd0);
      check("abort_metric", best_metric, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, 0);
      kick(20'd200, 28'd21000);
      wait_done();
      check("rerun_threshold", threshold, 8'd10);
      check("rerun_metric", best_metric, METRIC_BIMODAL);
      check("rerun_cycles", cyc, CYC_BIMODAL);
      after_done("rerun");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/otsu_threshold_sequencer.md
Name: otsu_threshold_sequencer

Overview:
- Sequences the Otsu threshold search over a 256-bin intensity histogram.
- Sweeps t = 0..255, reads one histogram bin per step and accumulates the background pixel count and background intensity sum.
- Computes the unnormalised between-class variance with an internal serial divider and keeps the best threshold.
- Sits between the histogram RAM and the binarisation stage; the binarisation stage consumes the `threshold` output.

Parameters:
- CNT_W, 20, width of a histogram bin count and of the total pixel count.
- Q_W, 2*(2*CNT_W+8) (localparam, default 96), width of the variance numerator and quotient.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  start a sweep; sampled only in IDLE
- total_count  input  CNT_W  total pixel count N; latched on accepted start
- total_sum  input  CNT_W+8  total intensity sum S; latched on accepted start
- hist_rd  output  1  histogram read strobe
- hist_addr  output  8  histogram bin address
- hist_data  input  CNT_W  bin count; valid exactly 1 cycle after hist_rd
- busy  output  1  high from accepted start until DONE
- done  output  1  one-cycle pulse when the result is valid
- threshold  output  8  best threshold; held until the next done
- best_metric  output  Q_W  variance metric of the best threshold; held

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, accumulators are cleared. Reset asserted mid-sweep aborts the sweep with no done pulse; `threshold` and `best_metric` return to 0.
- States: IDLE, READ, WAIT, ACC, DIV, CMP, DONE.
- IDLE: on start=1, latch N and S; clear t, w_b, sum_b, best_metric (0) and best_t (0); set busy; go to READ.
- Zero-pixel case: if N==0 at start, go directly to DONE.
- READ: hist_rd=1, hist_addr=t; go to WAIT.
- WAIT: one cycle for the RAM latency; go to ACC.
- ACC:
  - Update w_b += hist_data and sum_b += t*hist_data; w_f = N - w_b.
  - Candidate if w_b != 0 and w_f != 0. A candidate goes to DIV; otherwise go to next-step.
- DIV:
  - Numerator = (S*w_b - N*sum_b)^2, using the absolute value of the difference before squaring.
  - Denominator = w_b*w_f.
  - Restoring divider, one quotient bit per cycle, exactly Q_W cycles; the quotient is truncated.
- CMP: if quotient > best_metric (strictly greater), update best_metric and best_t=t. Ties keep the earlier (lower) t. Go to next-step.
- next-step: if t==255 go to DONE; else t=t+1 and go to READ. t never wraps.
- DONE: threshold=best_t, best_metric holds its final value, done=1 for one cycle, busy=0, return to IDLE.
- No candidate in the whole sweep: threshold=0, best_metric=0.
- Arithmetic widths:
  - w_b: CNT_W bits.
  - sum_b: CNT_W+8 bits.
  - Products S*w_b and N*sum_b: 2*CNT_W+8 bits.
  - No overflow is possible, provided sum of hist_data ≤ N and sum of t*hist_data ≤ S.
- Inconsistent inputs: if the histogram is inconsistent with N, so that w_b > N, treat w_f as 0 (no candidate); the sweep still completes.
- start while busy is ignored. The latched N and S are unaffected.
- Per-bin cost: 3 cycles (READ, WAIT, ACC), plus Q_W+1 cycles for a candidate bin.

Optional Feature:
- Macro: OTSU_SKIP_EMPTY_BIN_EN.
- Defined: a candidate bin with hist_data==0 skips DIV and CMP. Its variance equals the previous bin's, and the strict-greater rule would not update, so threshold and best_metric are identical to the non-macro build; only the cycle count drops.
- Undefined: every candidate bin is divided.

Test Plan:
1. Bimodal sweep: hist[10]=100, hist[200]=100, all other bins 0; N=200, S=21000. Expected response: done pulse, threshold=10, best_metric=361000000 (ties for t=11..199 are not taken).
2. Single populated bin: hist[128]=50, N=50, S=6400. No candidate exists, so expected response: threshold=0, best_metric=0, done is still pulsed after the full 256-bin sweep.
3. Empty image: N=0, start. Expected response: done pulse within 2 cycles, threshold=0, hist_rd never asserted.
4. start re-asserted at t=50 mid-sweep: ignored. hist_addr continues monotonically 0..255, exactly one done pulse, and the result matches test 1.
5. Reset asserted while in DIV at t=20: all outputs go to 0 and no done pulse occurs. A fresh start then reproduces the test 1 result.
6. Test 1 histogram built with and without OTSU_SKIP_EMPTY_BIN_EN. Expected response:
   - Identical threshold and best_metric in both builds.
   - The macro build finishes exactly 189*(Q_W+1) = 18333 cycles sooner (default Q_W=96).
